fetch_if_id: RTL

Instruction fetch stage plus IF/ID pipeline register, directly upstream of the immediate generator. It holds the PC and issues one instruction-memory request at a time over a valid/ready handshake. Each returned word is captured into the IF/ID register, whose id_instr output drives the immediate generator's Instruction32 input and the decoder. It supports decode-stage stalls through a one-entry skid buffer, and branch/jump redirects with kill of in-flight fetches.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_skid_buf.sv | 39 +++
 rtl/fetch_if_id.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int PC_W = 32;

  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [PC_W-1:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry instruction/pc holding slot for a word that returns while decode is stalled.
// Latency: written on the load edge, visible the cycle after; flush has priority over load.
// Backpressure: none of its own; the fetch FSM never loads it while it is full.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            unload,
  input  logic            flush,
  input  logic [PC_W-1:0] load_instr,
  input  logic [PC_W-1:0] load_pc,
  output logic            empty,
  output logic [PC_W-1:0] instr,
  output logic [PC_W-1:0] pc
);

  logic full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full  <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (load) begin
      full  <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

  assign empty = !full;

endmodule

// File: rtl/fetch_if_id.sv
// Instruction fetch FSM with IF/ID register; one outstanding imem request at a time.
// Latency: one instruction per 2 cycles at zero wait; first id_valid 3 edges after reset.
// Backpressure: stall_i holds IF/ID, one extra returning word parks in the skid slot.
module fetch_if_id
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [PC_W-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [PC_W-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [PC_W-1:0] imem_rsp_data,
  input  logic            stall_i,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            id_valid,
  output logic [PC_W-1:0] id_instr,
  output logic [PC_W-1:0] id_pc,
  output logic [PC_W-1:0] id_pc_plus4
);

  fetch_state_e    state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] req_pc;
  logic            kill;
  logic            req_valid_q;

  logic            slot_free;
  logic            skid_load;
  logic            skid_unload;
  logic            skid_empty;
  logic [PC_W-1:0] skid_instr;
  logic [PC_W-1:0] skid_pc;
  logic [PC_W-1:0] redirect_tgt;

  assign slot_free    = !id_valid || !stall_i;
  assign redirect_tgt = redirect_pc & ~32'h0000_0003;
  assign skid_load    = !redirect_valid && (state == WAIT) && imem_rsp_valid && !kill && !slot_free;
  assign skid_unload  = !redirect_valid && (state == HOLD) && !stall_i;

  fetch_skid_buf u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (skid_load),
    .unload     (skid_unload),
    .flush      (redirect_valid),
    .load_instr (imem_rsp_data),
    .load_pc    (req_pc),
    .empty      (skid_empty),
    .instr      (skid_instr),
    .pc         (skid_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_valid_q <= 1'b0;
      pc          <= RESET_PC;
      req_pc      <= '0;
      kill        <= 1'b0;
      id_valid    <= 1'b0;
      id_instr    <= NOP_INSTR;
      id_pc       <= '0;
    end else if (redirect_valid) begin
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
      pc       <= redirect_tgt;
      case (state)
        IDLE: begin
          state       <= REQ;
          req_valid_q <= 1'b1;
        end
        REQ: begin
          // Accepted in the same cycle: the word in flight is stale.
          if (imem_req_ready) begin
            kill        <= 1'b1;
            state       <= WAIT;
            req_valid_q <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            kill        <= 1'b0;
            state       <= REQ;
            req_valid_q <= 1'b1;
          end else begin
            kill <= 1'b1;
          end
        end
        HOLD: begin
          state       <= REQ;
          req_valid_q <= 1'b1;
        end
      endcase
    end else begin
      // Consumption; a load later in this block overrides it.
      if (id_valid && !stall_i) begin
        id_valid <= 1'b0;
        id_instr <= NOP_INSTR;
      end
      case (state)
        IDLE: begin
          state       <= REQ;
          req_valid_q <= 1'b1;
        end
        REQ: begin
          if (imem_req_ready) begin
            req_pc      <= pc;
            state       <= WAIT;
            req_valid_q <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            if (kill) begin
              kill        <= 1'b0;
              state       <= REQ;
              req_valid_q <= 1'b1;
            end else if (slot_free) begin
              id_valid    <= 1'b1;
              id_instr    <= imem_rsp_data;
              id_pc       <= req_pc;
              pc          <= req_pc + 32'd4;
              state       <= REQ;
              req_valid_q <= 1'b1;
            end else begin
              pc    <= req_pc + 32'd4;
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall_i) begin
            id_valid    <= 1'b1;
            id_instr    <= skid_instr;
            id_pc       <= skid_pc;
            state       <= REQ;
            req_valid_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc;
  assign id_pc_plus4    = id_pc + 32'd4;

endmodule
